// File: rtl/sobel_window_ctrl.sv
// 5x5 window former for a raster-order Sobel stage: four line buffers plus a
// column shift window feed an external kernel, whose result is registered out.
//
// state   | meaning
// S_IDLE  | waiting for start; no pixels accepted
// S_RUN   | accepting pixels of the current frame
// S_DRAIN | last pixel taken; flushing pending window and output register
module sobel_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   in_pixel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [199:0] window_out,
  input  logic [7:0]   kernel_pixel,
  output logic [7:0]   out_pixel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            win_pending;
  logic [7:0]      line_buf [4][IMG_W];
  logic [7:0]      win      [5][5];
  logic [7:0]      win_nxt  [5][5];
  logic [7:0]      new_col  [5];
  logic [199:0]    win_flat;
  logic            accept, last_pix, load_win, capture, col_last;

  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign last_pix = col_last && (row == RW'(IMG_H - 1));
  assign load_win = accept && (row >= RW'(4)) && (col >= CW'(4));
  assign capture  = win_pending && (!out_valid || out_ready);

  // line_buf[0] holds the row just above the current one, line_buf[3] the oldest
  always_comb begin
    new_col[0] = line_buf[3][col];
    new_col[1] = line_buf[2][col];
    new_col[2] = line_buf[1][col];
    new_col[3] = line_buf[0][col];
    new_col[4] = in_pixel;
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        win_nxt[i][j] = (j == 4) ? new_col[i] : win[i][j+1];
        win_flat[40*i + 8*j +: 8] = win_nxt[i][j];
      end
    end
  end

  // Pixel storage is deliberately unreset; windows only form after four fresh rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][col] <= in_pixel;
      line_buf[1][col] <= line_buf[0][col];
      line_buf[2][col] <= line_buf[1][col];
      line_buf[3][col] <= line_buf[2][col];
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          win[i][j] <= win_nxt[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      win_pending <= 1'b0;
      window_out  <= '0;
      out_pixel   <= '0;
      out_valid   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && start) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      if (load_win) window_out <= win_flat;

      if (state == S_IDLE && start) win_pending <= 1'b0;
      else if (load_win)            win_pending <= 1'b1;
      else if (capture)             win_pending <= 1'b0;

      if (capture) begin
        out_pixel <= kernel_pixel;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = !(win_pending && out_valid && !out_ready);
        if (in_valid && in_ready && last_pix) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!win_pending && !out_valid) begin
          frame_done = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl: table of frame scenarios, a reference Sobel
// kernel on window_out, and a scoreboard of expected outputs from the image.
module tb_sobel_window_ctrl;
  localparam int W = 8;
  localparam int H = 6;

  logic         clk = 0;
  logic         rst;
  logic         start;
  logic [7:0]   in_pixel;
  logic         in_valid;
  logic         in_ready;
  logic [199:0] window_out;
  logic [7:0]   kernel_pixel;
  logic [7:0]   out_pixel;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] img [H][W];
  logic [7:0] sbq [$];

  typedef struct {
    int pat;        // 0 const 100, 1 10*row, 2 250-10*row, 3 hashed texture
    int rmode;      // 0 always ready, 1 ten-cycle stall, 2 random
    int vmode;      // 0 always valid, 1 random
    bit mid_start;
    int rst_after;  // accepted pixels before a mid-frame reset, 0 = none
    int exp_count;
    int exp_const;  // -1 when values vary
  } rec_t;

  rec_t tbl [8];

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready), .window_out(window_out), .kernel_pixel(kernel_pixel),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done)
  );

  // 3x3 Sobel |Gx|+|Gy| saturated; m holds a 3x3 patch row-major
  function automatic logic [7:0] sob(input logic [71:0] m);
    int p [3][3];
    int gx, gy, s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = int'(m[(3*i+j)*8 +: 8]);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  always_comb begin
    logic [71:0] m;
    m = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[(3*i+j)*8 +: 8] = window_out[40*(i+1) + 8*(j+1) +: 8];
    kernel_pixel = sob(m);
  end

  function automatic logic [7:0] ref_at(input int rc, input int cc);
    logic [71:0] m;
    m = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[(3*i+j)*8 +: 8] = img[rc-1+i][cc-1+j];
    return sob(m);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fill_img(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0:       img[r][c] = 8'd100;
          1:       img[r][c] = 8'(10*r);
          2:       img[r][c] = 8'(250 - 10*r);
          default: img[r][c] = 8'((r*37 + c*91 + r*c*13) & 255);
        endcase
  endtask

  task automatic run_frame(input rec_t t);
    int idx, outs, fd, cyc, acc44, first_ov, stall_cnt, r, c;
    bit stalled, done, do_rst, did_rst;
    logic [7:0] held, exp_v;
    fill_img(t.pat);
    sbq.delete();
    idx = 0; outs = 0; fd = 0; cyc = 0; acc44 = -1; first_ov = -1;
    stall_cnt = 0; stalled = 0; done = 0; do_rst = 0; did_rst = 0; held = '0;

    // pixels offered while idle must not be taken
    @(negedge clk);
    in_valid = 1; in_pixel = 8'hAA; out_ready = 1; start = 0;
    #1;
    chk("idle_in_ready", int'(in_ready), 0);
    chk("idle_busy", int'(busy), 0);
    @(negedge clk);
    in_valid = 0; start = 1;
    @(negedge clk);
    start = 0;

    while (!done && cyc < 3000) begin
      if (cyc > 0) @(negedge clk);
      if (do_rst) begin
        do_rst = 0; in_valid = 0; rst = 1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_window_zero", int'(|window_out), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        sbq.delete();
        idx = 0; outs = 0; acc44 = -1; first_ov = -1;
        @(negedge clk);
        rst = 0; start = 1;
        @(negedge clk);
        start = 0;
      end

      start = t.mid_start && (cyc == 30);
      in_valid = (idx < W*H) && (t.vmode == 0 || $urandom_range(0, 1) == 1);
      in_pixel = in_valid ? img[idx / W][idx % W] : 8'($urandom);
      if (t.rmode == 1 && !stalled && idx == 4*W + 7) stalled = 1;
      if (t.rmode == 2)     out_ready = ($urandom_range(0, 1) == 1);
      else                  out_ready = !(stalled && stall_cnt < 10);
      #1;

      if (stalled && stall_cnt < 10) begin
        if (stall_cnt == 0) begin
          held = out_pixel;
          chk("stall_out_valid", int'(out_valid), 1);
        end else begin
          chk("stall_out_pixel_stable", int'(out_pixel), int'(held));
        end
        if (stall_cnt == 2) chk("stall_in_ready_low", int'(in_ready), 0);
        stall_cnt++;
      end

      if (acc44 >= 0 && cyc == acc44 + 1) begin
        chk("window_top_left", int'(window_out[7:0]), int'(img[0][0]));
        chk("window_bottom_right", int'(window_out[199:192]), int'(img[4][4]));
      end

      if (out_valid && first_ov < 0) first_ov = cyc;

      if (in_valid && in_ready) begin
        r = idx / W; c = idx % W;
        if (r >= 4 && c >= 4) sbq.push_back(ref_at(r - 2, c - 2));
        if (r == 4 && c == 4) acc44 = cyc;
        idx++;
        if (t.rst_after > 0 && !did_rst && idx == t.rst_after) begin
          did_rst = 1; do_rst = 1;
        end
      end

      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_v = sbq.pop_front();
          chk("out_pixel", int'(out_pixel), int'(exp_v));
        end
        if (t.exp_const >= 0) chk("out_pixel_const", int'(out_pixel), t.exp_const);
        outs++;
      end

      if (frame_done) begin
        fd++;
        chk("outputs_before_done", outs, t.exp_count);
        done = 1;
      end
      cyc++;
    end

    chk("frame_done_seen", int'(done), 1);
    chk("frame_done_count", fd, 1);
    chk("output_count", outs, t.exp_count);
    chk("scoreboard_empty", sbq.size(), 0);
    if (t.rmode == 0) chk("latency_44", first_ov - acc44, 2);
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("done_single_pulse", int'(frame_done), 0);
    chk("idle_after_frame", int'(busy), 0);
  endtask

  initial begin
    tbl[0] = '{pat:0, rmode:0, vmode:0, mid_start:0, rst_after:0,  exp_count:8, exp_const:0};
    tbl[1] = '{pat:1, rmode:0, vmode:0, mid_start:0, rst_after:0,  exp_count:8, exp_const:80};
    tbl[2] = '{pat:2, rmode:0, vmode:0, mid_start:0, rst_after:0,  exp_count:8, exp_const:80};
    tbl[3] = '{pat:3, rmode:1, vmode:0, mid_start:0, rst_after:0,  exp_count:8, exp_const:-1};
    tbl[4] = '{pat:3, rmode:0, vmode:1, mid_start:0, rst_after:0,  exp_count:8, exp_const:-1};
    tbl[5] = '{pat:3, rmode:2, vmode:1, mid_start:0, rst_after:0,  exp_count:8, exp_const:-1};
    tbl[6] = '{pat:1, rmode:0, vmode:0, mid_start:1, rst_after:0,  exp_count:8, exp_const:80};
    tbl[7] = '{pat:3, rmode:0, vmode:0, mid_start:0, rst_after:20, exp_count:8, exp_const:-1};

    rst = 1; start = 0; in_valid = 0; in_pixel = '0; out_ready = 1;
    #12;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_out_pixel", int'(out_pixel), 0);
    chk("reset_window", int'(|window_out), 0);
    @(negedge clk);
    rst = 0;

    for (int k = 0; k < 8; k++) run_frame(tbl[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
